// File: rtl/store_m_if.sv
// store_m_if: start/status, tile handshake and byte-write bus of store_m.
// STORE_M_BOUNDS_CHECK_EN adds the error flag to the bus.
interface store_m_if #(parameter int TILE_WIDTH = 256);
    logic                  valid_in;
    logic [23:0]           dram_addr;
    logic [19:0]           length;
    logic [TILE_WIDTH-1:0] tile_in;
    logic                  tile_valid;
    logic                  tile_ready;
    logic                  mem_we;
    logic [23:0]           mem_addr;
    logic [7:0]            mem_wdata;
    logic                  busy;
    logic                  valid_out;
`ifdef STORE_M_BOUNDS_CHECK_EN
    logic                  error;
    modport master(output valid_in, dram_addr, length, tile_in, tile_valid,
                   input tile_ready, mem_we, mem_addr, mem_wdata, busy, valid_out, error);
    modport slave(input valid_in, dram_addr, length, tile_in, tile_valid,
                  output tile_ready, mem_we, mem_addr, mem_wdata, busy, valid_out, error);
`else
    modport master(output valid_in, dram_addr, length, tile_in, tile_valid,
                   input tile_ready, mem_we, mem_addr, mem_wdata, busy, valid_out);
    modport slave(input valid_in, dram_addr, length, tile_in, tile_valid,
                  output tile_ready, mem_we, mem_addr, mem_wdata, busy, valid_out);
`endif
endinterface

// File: rtl/store_m.sv
// store_m: serialises TILE_WIDTH-bit tiles into length byte writes from dram_addr.
// Defining STORE_M_BOUNDS_CHECK_EN rejects transfers running past the 24-bit space.
module store_m #(
    parameter int TILE_WIDTH = 256,
    parameter int DATA_WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    store_m_if.slave bus
);
    localparam int NUM_BYTES = TILE_WIDTH / DATA_WIDTH;
    localparam int CW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_TILE, WRITING, DONE} state_t;

    state_t                state_q, state_d;
    logic [23:0]           ptr_q, ptr_d;
    logic [19:0]           rem_q, rem_d;
    logic [TILE_WIDTH-1:0] tile_q, tile_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [23:0]           addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  vo_q, vo_d;
    logic                  oob;
`ifdef STORE_M_BOUNDS_CHECK_EN
    logic                  oob_q, oob_d;
    logic                  err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        tile_d  = tile_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        vo_d    = state_q == DONE;
`ifdef STORE_M_BOUNDS_CHECK_EN
        oob     = ({1'b0, bus.dram_addr} + {5'b0, bus.length}) > 25'h100_0000;
        oob_d   = oob_q;
        err_d   = state_q == DONE && oob_q;
`else
        oob     = 1'b0;
`endif
        case (state_q)
            IDLE: if (bus.valid_in) begin
                ptr_d   = bus.dram_addr;
                rem_d   = bus.length;
                state_d = (bus.length == 20'd0 || oob) ? DONE : WAIT_TILE;
`ifdef STORE_M_BOUNDS_CHECK_EN
                oob_d   = oob;
`endif
            end
            WAIT_TILE: if (bus.tile_valid) begin
                tile_d  = bus.tile_in;
                cnt_d   = '0;
                state_d = WRITING;
            end
            WRITING: begin
                // the tile shifts left so the next byte is always at the MSB end
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = tile_q[TILE_WIDTH-1 -: DATA_WIDTH];
                tile_d  = tile_q << DATA_WIDTH;
                ptr_d   = ptr_q + 24'd1;
                rem_d   = rem_q - 20'd1;
                cnt_d   = cnt_q + 1'b1;
                state_d = rem_q == 20'd1 ? DONE : cnt_q == CW'(NUM_BYTES - 1) ? WAIT_TILE : WRITING;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            tile_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            vo_q    <= 1'b0;
`ifdef STORE_M_BOUNDS_CHECK_EN
            oob_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            tile_q  <= tile_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            vo_q    <= vo_d;
`ifdef STORE_M_BOUNDS_CHECK_EN
            oob_q   <= oob_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.tile_ready = state_q == WAIT_TILE;
    assign bus.busy       = state_q != IDLE;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.valid_out  = vo_q;
`ifdef STORE_M_BOUNDS_CHECK_EN
    assign bus.error      = err_q;
`endif
endmodule

// File: tb/tb_store_m.sv
// tb_store_m: directed tests of store_m write ordering, handshakes, stalls, reset and wrap.
module tb_store_m;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    store_m_if #(.TILE_WIDTH(256)) bus();
    store_m #(.TILE_WIDTH(256), .DATA_WIDTH(8)) dut(.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [255:0] tile_mem[4];
    logic [23:0]  wr_addr[128];
    logic [7:0]   wr_data[128];
    int cyc = 0, st_cyc = 0, we_cnt = 0, vo_cnt = 0, rdy_cnt = 0, hs_cnt = 0;
    int last_we_cyc = 0, vo_cyc = 0, err_cnt = 0, err_vo = 0;
    bit pend = 1'b0;
    bit src_en = 1'b0;

    // monitor and tile source, both on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (bus.mem_we) begin
            if (we_cnt < 128) begin
                wr_addr[we_cnt] = bus.mem_addr;
                wr_data[we_cnt] = bus.mem_wdata;
            end
            we_cnt++;
            last_we_cyc = cyc;
        end
        if (bus.valid_out) begin
            vo_cnt++;
            vo_cyc = cyc;
        end
        if (bus.tile_ready) rdy_cnt++;
`ifdef STORE_M_BOUNDS_CHECK_EN
        if (bus.error) begin
            err_cnt++;
            if (bus.valid_out) err_vo++;
        end
`endif
        if (pend) hs_cnt++;
        bus.tile_in    = tile_mem[hs_cnt % 4];
        bus.tile_valid = src_en;
        pend = bus.tile_ready && bus.tile_valid;
    end

    task automatic clear();
        we_cnt = 0; vo_cnt = 0; rdy_cnt = 0; hs_cnt = 0; err_cnt = 0; err_vo = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic start(input logic [23:0] a, input logic [19:0] l);
        @(negedge clk);
        #1;
        bus.valid_in  = 1'b1;
        bus.dram_addr = a;
        bus.length    = l;
        st_cyc = cyc;
        tick(1);
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (vo_cnt == 0 && n < maxc) begin
            tick(1);
            n++;
        end
        tick(4);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        total++;
        if ({bus.tile_ready, bus.mem_we, bus.busy, bus.valid_out, bus.mem_addr, bus.mem_wdata} !== 36'd0) begin
            bad++;
            $display("FAIL reset_outputs got ready=%b we=%b busy=%b vo=%b addr=%h data=%h want all 0",
                     bus.tile_ready, bus.mem_we, bus.busy, bus.valid_out, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_single_tile();
        clear();
        src_en = 1'b1;
        start(24'h000100, 20'd32);
        wait_done(100);
        total++;
        if (we_cnt !== 32) begin bad++; $display("FAIL single_count got %0d want 32", we_cnt); end
        for (int i = 0; i < 32; i++) begin
            total++;
            if (wr_addr[i] !== 24'h100 + 24'(i) || wr_data[i] !== 8'(i)) begin
                bad++;
                $display("FAIL single_write[%0d] got %h:%h want %h:%h", i, wr_addr[i], wr_data[i], 24'h100 + 24'(i), 8'(i));
            end
        end
        total++;
        if (vo_cnt !== 1 || vo_cyc !== last_we_cyc + 1) begin
            bad++;
            $display("FAIL single_valid_out got count=%0d cyc=%0d want 1 at %0d", vo_cnt, vo_cyc, last_we_cyc + 1);
        end
        total++;
        if (rdy_cnt !== 1) begin bad++; $display("FAIL single_ready got %0d want 1", rdy_cnt); end
    endtask

    task automatic test_two_tiles();
        clear();
        src_en = 1'b1;
        start(24'h000000, 20'd40);
        wait_done(150);
        total++;
        if (we_cnt !== 40) begin bad++; $display("FAIL two_count got %0d want 40", we_cnt); end
        for (int i = 0; i < 40; i++) begin
            total++;
            if (wr_addr[i] !== 24'(i) || wr_data[i] !== 8'(i)) begin
                bad++;
                $display("FAIL two_write[%0d] got %h:%h want %h:%h", i, wr_addr[i], wr_data[i], 24'(i), 8'(i));
            end
        end
        total++;
        if (rdy_cnt !== 2) begin bad++; $display("FAIL two_ready got %0d want 2", rdy_cnt); end
        total++;
        if (vo_cnt !== 1 || vo_cyc !== last_we_cyc + 1) begin
            bad++;
            $display("FAIL two_valid_out got count=%0d cyc=%0d want 1 at %0d", vo_cnt, vo_cyc, last_we_cyc + 1);
        end
    endtask

    task automatic test_zero_length();
        clear();
        src_en = 1'b1;
        start(24'h000500, 20'd0);
        wait_done(20);
        total++;
        if (vo_cnt !== 1 || vo_cyc !== st_cyc + 2) begin
            bad++;
            $display("FAIL zero_valid_out got count=%0d cyc=%0d want 1 at %0d", vo_cnt, vo_cyc, st_cyc + 2);
        end
        total++;
        if (we_cnt !== 0 || rdy_cnt !== 0) begin
            bad++;
            $display("FAIL zero_activity got we=%0d ready=%0d want 0 0", we_cnt, rdy_cnt);
        end
    endtask

    task automatic test_stall();
        int stall_bad = 0;
        clear();
        src_en = 1'b0;
        start(24'h000200, 20'd8);
        for (int i = 0; i < 10; i++) begin
            if (!(bus.busy === 1'b1 && bus.mem_we === 1'b0 && bus.tile_ready === 1'b1)) stall_bad++;
            bus.valid_in  = i == 4;
            bus.dram_addr = 24'h000900;
            bus.length    = 20'd3;
            tick(1);
        end
        bus.valid_in = 1'b0;
        total++;
        if (stall_bad !== 0) begin bad++; $display("FAIL stall_wait got %0d bad cycles want 0", stall_bad); end
        src_en = 1'b1;
        wait_done(60);
        total++;
        if (we_cnt !== 8) begin bad++; $display("FAIL stall_count got %0d want 8", we_cnt); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (wr_addr[i] !== 24'h200 + 24'(i) || wr_data[i] !== 8'(i)) begin
                bad++;
                $display("FAIL stall_write[%0d] got %h:%h want %h:%h", i, wr_addr[i], wr_data[i], 24'h200 + 24'(i), 8'(i));
            end
        end
        total++;
        if (vo_cnt !== 1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_done got vo=%0d busy=%b want 1 0", vo_cnt, bus.busy);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        int w;
        clear();
        src_en = 1'b1;
        start(24'h000300, 20'd64);
        while (we_cnt < 5 && n < 50) begin
            tick(1);
            n++;
        end
        rst = 1'b0;
        tick(1);
        total++;
        if ({bus.tile_ready, bus.mem_we, bus.busy, bus.valid_out, bus.mem_addr, bus.mem_wdata} !== 36'd0) begin
            bad++;
            $display("FAIL midreset_outputs got ready=%b we=%b busy=%b vo=%b addr=%h data=%h want all 0",
                     bus.tile_ready, bus.mem_we, bus.busy, bus.valid_out, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b1;
        w = we_cnt;
        tick(80);
        total++;
        if (we_cnt !== w || vo_cnt !== 0 || w < 5) begin
            bad++;
            $display("FAIL midreset_quiet got we=%0d (at reset %0d) vo=%0d want no change and no valid_out", we_cnt, w, vo_cnt);
        end
        clear();
        start(24'h000400, 20'd16);
        wait_done(60);
        total++;
        if (we_cnt !== 16 || vo_cnt !== 1) begin
            bad++;
            $display("FAIL restart_count got we=%0d vo=%0d want 16 1", we_cnt, vo_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (wr_addr[i] !== 24'h400 + 24'(i) || wr_data[i] !== 8'(i)) begin
                bad++;
                $display("FAIL restart_write[%0d] got %h:%h want %h:%h", i, wr_addr[i], wr_data[i], 24'h400 + 24'(i), 8'(i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [23:0] exp_a[4];
        exp_a[0] = 24'hFFFFFE; exp_a[1] = 24'hFFFFFF; exp_a[2] = 24'h000000; exp_a[3] = 24'h000001;
        clear();
        src_en = 1'b1;
        start(24'hFFFFFE, 20'd4);
        wait_done(40);
        total++;
        if (vo_cnt !== 1) begin bad++; $display("FAIL wrap_valid_out got %0d want 1", vo_cnt); end
`ifdef STORE_M_BOUNDS_CHECK_EN
        total++;
        if (we_cnt !== 0 || rdy_cnt !== 0) begin
            bad++;
            $display("FAIL bounds_activity got we=%0d ready=%0d want 0 0", we_cnt, rdy_cnt);
        end
        total++;
        if (err_cnt !== 1 || err_vo !== 1) begin
            bad++;
            $display("FAIL bounds_error got cycles=%0d with_vo=%0d want 1 1", err_cnt, err_vo);
        end
`else
        total++;
        if (we_cnt !== 4) begin bad++; $display("FAIL wrap_count got %0d want 4", we_cnt); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wr_addr[i] !== exp_a[i] || wr_data[i] !== 8'(i)) begin
                bad++;
                $display("FAIL wrap_write[%0d] got %h:%h want %h:%h", i, wr_addr[i], wr_data[i], exp_a[i], 8'(i));
            end
        end
`endif
    endtask

    initial begin
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 32; j++)
                tile_mem[k][255 - 8*j -: 8] = 8'(k*32 + j);
        bus.valid_in  = 1'b0;
        bus.dram_addr = '0;
        bus.length    = '0;
        test_reset();
        test_single_tile();
        test_two_tiles();
        test_zero_length();
        test_stall();
        test_mid_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
